// File: rtl/matrix_multiply_core3x3_mac.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_multiply_core3x3_mac
//  Purpose  : Sequential 3x3 fixed-point matrix-vector multiply-accumulate.
//             Collects a 3-element signed input vector, multiplies it by a
//             programmable 3x3 coefficient matrix using a single multiplier
//             (one product per cycle), and emits one {valid, data} word per
//             output row.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SHIFT            arithmetic right shift applied to each row sum before
//                     saturation (14 -> Q2.14 coefficients)
//  Ports
//    system1000       clock, rising edge
//    system1000_rstn  asynchronous reset, active low
//    coef_we          coefficient write strobe
//    coef_addr [3:0]  coefficient index, row-major 3*row+col; 9..15 ignored
//    coef_data [15:0] signed coefficient value
//    in_valid         input sample valid
//    in_data   [15:0] signed input sample
//    in_ready         engine accepts a sample this cycle (COLLECT state)
//    result    [32:0] {valid, signed data[31:0]}; data holds when valid low
// ============================================================================
module matrix_multiply_core3x3_mac #(
    parameter int SHIFT = 14
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [15:0] coef_data,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [32:0] result
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        MAC     = 1'b1
    } state_t;

    localparam logic signed [33:0] SAT_MAX   = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] SAT_MIN   = 34'sh3_8000_0000;
    localparam logic signed [15:0] COEF_ONE  = 16'sd16384;

    state_t             state;
    state_t             state_next;
    logic [1:0]         cnt;
    logic [1:0]         row;
    logic [1:0]         col;
    logic signed [33:0] acc;
    logic signed [15:0] x    [0:2];
    logic signed [15:0] coef [0:8];
    logic [32:0]        result_q;

    logic [3:0]         mac_idx;
    logic signed [15:0] coef_sel;
    logic signed [15:0] x_sel;
    logic signed [31:0] coef_ext;
    logic signed [31:0] x_ext;
    logic signed [31:0] prod;
    logic signed [33:0] acc_next;
    logic signed [33:0] shifted;
    logic [31:0]        sat_data;

    // ------------------------------------------------------------------
    // Datapath: one coefficient * sample product per MAC cycle. The
    // coefficient is read from the register array before any write at
    // the same edge lands, so a coincident write affects later cycles only.
    // ------------------------------------------------------------------
    assign mac_idx  = ({2'b00, row} * 4'd3) + {2'b00, col};
    assign coef_sel = coef[mac_idx];
    assign x_sel    = x[col];
    assign coef_ext = $signed({{16{coef_sel[15]}}, coef_sel});
    assign x_ext    = $signed({{16{x_sel[15]}}, x_sel});
    assign prod     = coef_ext * x_ext;
    assign acc_next = acc + $signed({{2{prod[31]}}, prod});
    // Arithmetic shift: rounds toward minus infinity.
    assign shifted  = acc_next >>> SHIFT;

    always_comb begin
        sat_data = shifted[31:0];
        if (shifted > SAT_MAX) begin
            sat_data = 32'h7FFF_FFFF;
        end else if (shifted < SAT_MIN) begin
            sat_data = 32'h8000_0000;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == 2'd2)) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if ((row == 2'd2) && (col == 2'd2)) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, sample buffer, accumulator and result register
    // ------------------------------------------------------------------
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt      <= 2'd0;
            row      <= 2'd0;
            col      <= 2'd0;
            acc      <= '0;
            result_q <= 33'd0;
            for (int i = 0; i < 3; i++) begin
                x[i] <= '0;
            end
        end else begin
            // Valid is a single-cycle pulse; data holds its last value.
            result_q[32] <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        x[cnt] <= in_data;
                        if (cnt == 2'd2) begin
                            cnt <= 2'd0;
                            row <= 2'd0;
                            col <= 2'd0;
                            acc <= '0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                MAC: begin
                    if (col == 2'd2) begin
                        result_q <= {1'b1, sat_data};
                        acc      <= '0;
                        col      <= 2'd0;
                        row      <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                    end else begin
                        acc <= acc_next;
                        col <= col + 2'd1;
                    end
                end
                default: begin
                    cnt <= 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coefficient store; resets to the Q2.14 identity matrix.
    // ------------------------------------------------------------------
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < 9; i++) begin
                coef[i] <= ((i % 4) == 0) ? COEF_ONE : 16'sd0;
            end
        end else if (coef_we && (coef_addr < 4'd9)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiply_core3x3_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_multiply_core3x3_mac
//  Purpose  : Self-checking bench for matrix_multiply_core3x3_mac. Two
//             instances share all inputs: one with the default SHIFT of 14
//             and one with SHIFT = 0 for the saturation vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_multiply_core3x3_mac;

    logic        system1000;
    logic        system1000_rstn;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        in_valid;
    logic [15:0] in_data;
    logic        ready_a;
    logic        ready_s0;
    logic [32:0] result_a;
    logic [32:0] result_s0;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_multiply_core3x3_mac #(.SHIFT(14)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (ready_a),
        .result          (result_a)
    );

    matrix_multiply_core3x3_mac #(.SHIFT(0)) dut_s0 (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (ready_s0),
        .result          (result_s0)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    // mode: 0 = reset identity, 1 = coefficients 1..9, 2 = all -32768,
    //       3 = identity written explicitly. sel: 0 = SHIFT 14, 1 = SHIFT 0.
    typedef struct {
        int mode;
        int sel;
        int x0, x1, x2;
        int e0, e1, e2;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge system1000);
        system1000_rstn = 1'b0;
        coef_we   = 1'b0;
        in_valid  = 1'b0;
        repeat (2) @(negedge system1000);
        system1000_rstn = 1'b1;
    endtask

    task automatic load_coefs(input int mode);
        for (int a = 0; a < 16; a++) begin
            @(negedge system1000);
            coef_we   = 1'b1;
            coef_addr = 4'(a);
            if (a > 8)          coef_data = 16'h5A5A;   // must be ignored
            else if (mode == 1) coef_data = 16'(a + 1);
            else if (mode == 2) coef_data = 16'h8000;
            else                coef_data = ((a % 4) == 0) ? 16'd16384 : 16'd0;
        end
        @(negedge system1000);
        coef_we = 1'b0;
    endtask

    // Drive three consecutive samples; the edge after the last is E0.
    task automatic push3(input int x0, input int x1, input int x2, input int sel);
        int xs [3];
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        for (int i = 0; i < 3; i++) begin
            @(negedge system1000);
            check("in_ready_collect", sel ? ready_s0 : ready_a, 1);
            in_valid = 1'b1;
            in_data  = 16'(xs[i]);
        end
    endtask

    // Starts just before the negedge following E0; observes E1..E10.
    task automatic get_results(input int sel, input int e0, input int e1, input int e2);
        int          exp_d [3];
        logic [32:0] r;
        logic        rdy;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2;
        @(negedge system1000);
        in_valid = 1'b0;
        check("in_ready_after_E0", sel ? ready_s0 : ready_a, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge system1000);
            r   = sel ? result_s0 : result_a;
            rdy = sel ? ready_s0 : ready_a;
            check("in_ready_mac", rdy, (k >= 9) ? 1 : 0);
            if ((k % 3 == 0) && (k <= 9)) begin
                check("valid_row", r[32], 1);
                check("data_row", $signed(r[31:0]), exp_d[k / 3 - 1]);
            end else begin
                check("valid_idle", r[32], 0);
            end
        end
    endtask

    initial begin
        system1000_rstn = 1'b0;
        coef_we   = 1'b0;
        coef_addr = 4'd0;
        coef_data = 16'd0;
        in_valid  = 1'b0;
        in_data   = 16'd0;

        tbl[0] = '{0, 0, 100, -200, 300, 100, -200, 300};
        tbl[1] = '{1, 0, 16384, 16384, 16384, 6, 15, 24};
        tbl[2] = '{2, 1, -32768, -32768, -32768,
                   32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        tbl[3] = '{2, 1, 32767, 32767, 32767,
                   32'sh80000000, 32'sh80000000, 32'sh80000000};
        tbl[4] = '{1, 0, -1, -1, -1, -1, -1, -1};
        tbl[5] = '{3, 0, 32767, -32768, 0, 32767, -32768, 0};
        tbl[6] = '{1, 1, 1, 2, 3, 14, 32, 50};

        // Reset state
        #2;
        check("reset_result", result_a, 0);
        check("reset_ready", ready_a, 1);
        check("reset_result_s0", result_s0, 0);
        system1000_rstn = 1'b1;

        // Table-driven vectors
        for (int t = 0; t < 7; t++) begin
            do_reset();
            if (tbl[t].mode != 0) load_coefs(tbl[t].mode);
            push3(tbl[t].x0, tbl[t].x1, tbl[t].x2, tbl[t].sel);
            get_results(tbl[t].sel, tbl[t].e0, tbl[t].e1, tbl[t].e2);
        end

        // Backpressure: in_valid held high, sample value advances per accept.
        do_reset();
        begin
            int next_s;
            int v;
            next_s = 1;
            for (int c = 0; c <= 60; c++) begin
                @(negedge system1000);
                v = c / 12;
                check("bp_ready", ready_a, ((c % 12) < 3) ? 1 : 0);
                if ((c >= 6) && ((c % 12 == 6) || (c % 12 == 9) || (c % 12 == 0))) begin
                    check("bp_valid", result_a[32], 1);
                    if (c % 12 == 6)      check("bp_data", $signed(result_a[31:0]), 3 * v + 1);
                    else if (c % 12 == 9) check("bp_data", $signed(result_a[31:0]), 3 * v + 2);
                    else                  check("bp_data", $signed(result_a[31:0]), 3 * (v - 1) + 3);
                end else begin
                    check("bp_valid_idle", result_a[32], 0);
                end
                in_valid = 1'b1;
                if ((c % 12) < 3) next_s = 3 * v + (c % 12) + 1;
                else              next_s = 3 * (v + 1) + 1;
                in_data = 16'(next_s);
            end
            in_valid = 1'b0;
        end

        // Input gaps and floor rounding on identity
        do_reset();
        begin
            bit pat [6];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 6; i++) begin
                @(negedge system1000);
                if (i > 0) check("gap_no_valid", result_a[32], 0);
                in_valid = pat[i];
                in_data  = pat[i] ? 16'hFFFF : 16'h1111;
            end
            get_results(0, -1, -1, -1);
        end

        // Reset mid-MAC after the row-0 pulse; coefficients revert to identity.
        do_reset();
        load_coefs(1);
        push3(16384, 16384, 16384, 0);
        @(negedge system1000);
        in_valid = 1'b0;
        repeat (3) @(negedge system1000);
        check("mid_row0_valid", result_a[32], 1);
        check("mid_row0_data", $signed(result_a[31:0]), 6);
        system1000_rstn = 1'b0;
        #1;
        check("mid_reset_result", result_a, 0);
        check("mid_reset_ready", ready_a, 1);
        repeat (3) @(negedge system1000);
        check("mid_reset_hold", result_a, 0);
        system1000_rstn = 1'b1;
        push3(7, 8, 9, 0);
        get_results(0, 7, 8, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
